rsc_encoder: RTL and testbench

RSC_ENCODER -- requirements
Module: rsc_encoder

---
 rtl/rsc_encoder_if.sv | 36 +++
 rtl/rsc_encoder.sv | 107 ++++++++++
 tb/tb_rsc_encoder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/rsc_encoder_if.sv
// Handshake and output bundle between the interleaver/consumer side and the RSC encoder.
interface rsc_encoder_if;
    logic       start;
    logic [7:0] data_in;
    logic       busy;
    logic       out_valid;
    logic       sys_out;
    logic       par_out;
    logic       tail;
    logic       done;
    logic [7:0] parity_byte;

    modport master (
        output start,
        output data_in,
        input  busy,
        input  out_valid,
        input  sys_out,
        input  par_out,
        input  tail,
        input  done,
        input  parity_byte
    );

    modport slave (
        input  start,
        input  data_in,
        output busy,
        output out_valid,
        output sys_out,
        output par_out,
        output tail,
        output done,
        output parity_byte
    );
endinterface

// File: rtl/rsc_encoder.sv
// 8-state recursive systematic convolutional encoder: one byte per block, MSB first,
// with optional 3-cycle trellis termination.
module rsc_encoder #(
    parameter bit TAIL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    rsc_encoder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ENC, TERM} state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] data_sr;
    logic [7:0] par_sr;
    logic [2:0] cnt;
    logic       s1;
    logic       s2;
    logic       s3;
    logic       u;
    logic       a;
    logic       par;
    logic       active;
    logic       last_enc;
    logic       last_term;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = ENC;
            ENC:     if (last_enc)  next_state = TAIL_EN ? TERM : IDLE;
            TERM:    if (last_term) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded purely from registered state, so the first pair
    // appears in the cycle right after the accepting edge.
    assign u         = (state == TERM) ? (s2 ^ s3) : data_sr[7];
    assign a         = u ^ s2 ^ s3;
    assign par       = a ^ s1 ^ s3;
    assign active    = (state != IDLE);
    assign last_enc  = (state == ENC)  && (cnt == 3'd7);
    assign last_term = (state == TERM) && (cnt == 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            data_sr <= 8'h00;
            par_sr  <= 8'h00;
            cnt     <= 3'd0;
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        data_sr <= bus.data_in;
                        par_sr  <= 8'h00;
                        cnt     <= 3'd0;
                        s1      <= 1'b0;
                        s2      <= 1'b0;
                        s3      <= 1'b0;
                    end
                end
                ENC: begin
                    data_sr <= {data_sr[6:0], 1'b0};
                    par_sr  <= {par_sr[6:0], par};
                    cnt     <= cnt + 3'd1;
                    s1      <= a;
                    s2      <= s1;
                    s3      <= s2;
                end
                TERM: begin
                    cnt <= last_term ? 3'd0 : cnt + 3'd1;
                    s1  <= a;
                    s2  <= s1;
                    s3  <= s2;
                end
                default: begin
                    cnt <= 3'd0;
                end
            endcase
        end
    end

    assign bus.busy      = active;
    assign bus.out_valid = active;
    assign bus.sys_out   = active & u;
    assign bus.par_out   = active & par;
    assign bus.tail      = (state == TERM);
    assign bus.done      = (last_enc && !TAIL_EN) || last_term;

    // Splice in the 8th parity bit during the last data cycle so the byte is
    // complete on the done pulse even without termination.
    assign bus.parity_byte = last_enc ? {par_sr[6:0], par} : par_sr;

endmodule

// File: tb/tb_rsc_encoder.sv
// Directed scoreboard bench for rsc_encoder, with one instance per TAIL_EN setting.
module tb_rsc_encoder;

    typedef struct packed {
        logic vld;
        logic sys;
        logic par;
        logic tl;
        logic dn;
    } pair_t;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   errors  = 0;
    pair_t exp_q[$];
    logic [7:0] pb;

    always #5 clk = ~clk;

    rsc_encoder_if bus  ();
    rsc_encoder_if bus0 ();

    rsc_encoder #(.TAIL_EN(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    rsc_encoder #(.TAIL_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic pair_t observe(input bit sel);
        pair_t o;
        if (sel) o = {bus0.out_valid, bus0.sys_out, bus0.par_out, bus0.tail, bus0.done};
        else     o = {bus.out_valid,  bus.sys_out,  bus.par_out,  bus.tail,  bus.done};
        return o;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? bus0.busy : bus.busy;
    endfunction

    function automatic logic [7:0] get_pb(input bit sel);
        return sel ? bus0.parity_byte : bus.parity_byte;
    endfunction

    // Reference trellis, written straight from the recursion equations.
    task automatic push_model(input logic [7:0] d, input bit tail_en, output logic [7:0] pbyte);
        logic m1, m2, m3, uu, aa, pp;
        pair_t e;
        m1 = 1'b0; m2 = 1'b0; m3 = 1'b0; pbyte = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            uu = d[i];
            aa = uu ^ m2 ^ m3;
            pp = aa ^ m1 ^ m3;
            e.vld = 1'b1; e.sys = uu; e.par = pp; e.tl = 1'b0;
            e.dn  = (!tail_en && i == 0);
            exp_q.push_back(e);
            pbyte = {pbyte[6:0], pp};
            m3 = m2; m2 = m1; m1 = aa;
        end
        if (tail_en) begin
            for (int t = 0; t < 3; t++) begin
                uu = m2 ^ m3;
                pp = m1 ^ m3;
                e.vld = 1'b1; e.sys = uu; e.par = pp; e.tl = 1'b1; e.dn = (t == 2);
                exp_q.push_back(e);
                m3 = m2; m2 = m1; m1 = 1'b0;
            end
        end
    endtask

    // Hand-derived output stream for data 0x80 with termination.
    task automatic push_const_80(input int n);
        logic [10:0] sys_seq;
        logic [10:0] par_seq;
        pair_t e;
        sys_seq = 11'b1000_0000_011;
        par_seq = 11'b1111_0010_101;
        for (int i = 0; i < n; i++) begin
            e.vld = 1'b1;
            e.sys = sys_seq[10 - i];
            e.par = par_seq[10 - i];
            e.tl  = (i >= 8);
            e.dn  = (i == 10);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_idle();
        pair_t e;
        e = '0;
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus(input bit sel, input logic [7:0] d);
        if (sel) begin
            bus0.start = 1'b1; bus0.data_in = d;
        end else begin
            bus.start = 1'b1; bus.data_in = d;
        end
        @(negedge clk);
        if (sel) bus0.start = 1'b0;
        else     bus.start  = 1'b0;
    endtask

    task automatic check_output(input bit sel, input string name, input int release_idx, input int rst_idx);
        pair_t e;
        pair_t o;
        int idx;
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = observe(sel);
            check($sformatf("%s[%0d].valid", name, idx), {7'd0, o.vld}, {7'd0, e.vld});
            check($sformatf("%s[%0d].sys",   name, idx), {7'd0, o.sys}, {7'd0, e.sys});
            check($sformatf("%s[%0d].par",   name, idx), {7'd0, o.par}, {7'd0, e.par});
            check($sformatf("%s[%0d].tail",  name, idx), {7'd0, o.tl},  {7'd0, e.tl});
            check($sformatf("%s[%0d].done",  name, idx), {7'd0, o.dn},  {7'd0, e.dn});
            check($sformatf("%s[%0d].busy",  name, idx), {7'd0, get_busy(sel)}, {7'd0, e.vld});
            if (idx == release_idx) bus.start = 1'b0;
            if (idx == rst_idx)     rst = 1'b1;
            idx++;
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input bit sel, input string name, input logic [7:0] exp_pb);
        pair_t o;
        o = observe(sel);
        check({name, ".valid"}, {7'd0, o.vld}, 8'h00);
        check({name, ".sys"},   {7'd0, o.sys}, 8'h00);
        check({name, ".par"},   {7'd0, o.par}, 8'h00);
        check({name, ".tail"},  {7'd0, o.tl},  8'h00);
        check({name, ".done"},  {7'd0, o.dn},  8'h00);
        check({name, ".busy"},  {7'd0, get_busy(sel)}, 8'h00);
        check({name, ".parity_byte"}, get_pb(sel), exp_pb);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;  bus.data_in = 8'h00;
        bus0.start = 1'b0; bus0.data_in = 8'h00;
        repeat (2) @(negedge clk);
        check_idle(1'b0, "reset", 8'h00);
        check_idle(1'b1, "reset_notail", 8'h00);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] all-zero block");
        push_model(8'h00, 1'b1, pb);
        apply_stimulus(1'b0, 8'h00);
        check_output(1'b0, "zero", -1, -1);
        check_idle(1'b0, "zero_end", 8'h00);

        $display("[TB] 0x80 reference block");
        push_const_80(11);
        apply_stimulus(1'b0, 8'h80);
        check_output(1'b0, "b80", -1, -1);
        check_idle(1'b0, "b80_end", 8'hF2);

        $display("[TB] assorted data patterns");
        push_model(8'hA5, 1'b1, pb);
        apply_stimulus(1'b0, 8'hA5);
        check_output(1'b0, "bA5", -1, -1);
        check_idle(1'b0, "bA5_end", pb);
        push_model(8'h3C, 1'b1, pb);
        apply_stimulus(1'b0, 8'h3C);
        check_output(1'b0, "b3C", -1, -1);
        check_idle(1'b0, "b3C_end", pb);

        $display("[TB] start held high across two blocks");
        push_const_80(11);
        push_idle();
        push_model(8'h00, 1'b1, pb);
        bus.start = 1'b1; bus.data_in = 8'h80;
        @(negedge clk);
        bus.data_in = 8'h00;
        check_output(1'b0, "b2b", 12, -1);
        check_idle(1'b0, "b2b_end", 8'h00);

        $display("[TB] reset in the 5th data cycle");
        push_const_80(5);
        apply_stimulus(1'b0, 8'h80);
        check_output(1'b0, "midrst", -1, 4);
        check_idle(1'b0, "midrst_after", 8'h00);
        rst = 1'b0;
        @(negedge clk);
        push_const_80(11);
        apply_stimulus(1'b0, 8'h80);
        check_output(1'b0, "rerun", -1, -1);
        check_idle(1'b0, "rerun_end", 8'hF2);

        $display("[TB] no termination instance");
        push_model(8'h80, 1'b0, pb);
        apply_stimulus(1'b1, 8'h80);
        check_output(1'b1, "notail", -1, -1);
        check_idle(1'b1, "notail_end", 8'hF2);

        $display("[TB] reset beats start");
        bus.start = 1'b1; bus.data_in = 8'h80; rst = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; rst = 1'b0;
        check_idle(1'b0, "rst_start", 8'h00);
        @(negedge clk);
        check_idle(1'b0, "rst_start_next", 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
